uart_tx: RTL and testbench

- Serial UART transmitter, 8N1 by default, with optional parity and a second stop bit.
- Takes a byte with a single-cycle data-valid strobe and drives an idle-high serial line, LSB first.
- Pairs with the existing UART receiver at the same CLKS_PER_BIT and is the TX half of the UART link.
- Reports busy and done to the upstream byte source.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_baud_cnt.sv | 31 +++
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and default bit period.
// uart_tx and uart_rx both use these, so the encodings stay consistent across the link.
package uart_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_CLEANUP = 3'd5;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int CLKS_PER_BIT_DEF = 87;

  // Even parity makes the total count of ones even; odd parity makes it odd.
  function automatic logic parity_of(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-side handshake and serial outputs of the UART transmitter.
// The master is the upstream byte source; the slave is the transmitter.
interface uart_tx_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Done;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Serial,
    input  o_Tx_Active,
    input  o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Serial,
    output o_Tx_Active,
    output o_Tx_Done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
// Written to be shared by the transmitter and a later receiver rework.
module uart_baud_cnt import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Tc
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Wraps to zero on terminal count so consecutive bits need no explicit clear.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cnt <= '0;
    end else if (i_Clear) begin
      cnt <= '0;
    end else if (i_Enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign o_Tc = i_Enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Every output is a register; the line is idle-high.
module uart_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  uart_tx_if.slave  tx
);

  // Out-of-range parameter values fall back to no parity / one stop bit.
  localparam int PAR_MODE = (PARITY == PARITY_ODD || PARITY == PARITY_EVEN) ? PARITY : PARITY_NONE;
  localparam logic STOP_LAST = (STOP_BITS == 2);

  logic [2:0] state;
  logic [7:0] tx_data;
  logic [2:0] bit_idx;
  logic [2:0] nxt_idx;
  logic       stop_idx;
  logic       par_bit;
  logic       serial_r;
  logic       active_r;
  logic       done_r;
  logic       baud_en;
  logic       baud_clr;
  logic       bit_end;

  always_comb begin
    baud_en  = (state == S_START) || (state == S_DATA) ||
               (state == S_PARITY) || (state == S_STOP);
    baud_clr = ~baud_en;
  end

  assign nxt_idx = bit_idx + 3'd1;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (baud_clr),
    .i_Enable (baud_en),
    .o_Tc     (bit_end)
  );

  // The line register is loaded with the next bit's level on the same edge the state advances.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= S_IDLE;
      tx_data  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      serial_r <= 1'b1;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          serial_r <= 1'b1;
          done_r   <= 1'b0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          if (tx.i_Tx_DV) begin
            tx_data  <= tx.i_Tx_Byte;
            par_bit  <= parity_of(tx.i_Tx_Byte, PAR_MODE);
            serial_r <= 1'b0;
            active_r <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_idx  <= '0;
            serial_r <= tx_data[0];
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PAR_MODE != PARITY_NONE) begin
                serial_r <= par_bit;
                state    <= S_PARITY;
              end else begin
                serial_r <= 1'b1;
                state    <= S_STOP;
              end
            end else begin
              bit_idx  <= nxt_idx;
              serial_r <= tx_data[nxt_idx];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            serial_r <= 1'b1;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop_idx == STOP_LAST) begin
              stop_idx <= 1'b0;
              active_r <= 1'b0;
              done_r   <= 1'b1;
              state    <= S_CLEANUP;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        S_CLEANUP: begin
          serial_r <= 1'b1;
          done_r   <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          serial_r <= 1'b1;
          active_r <= 1'b0;
          done_r   <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx.o_Tx_Serial = serial_r;
  assign tx.o_Tx_Active = active_r;
  assign tx.o_Tx_Done   = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five configurations side by side, per-cycle scoreboard of line/active/done,
// plus a serial receiver model for the 87-clock loopback.
module tb_uart_tx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] dv = '0;
  logic [7:0] tx_byte = '0;
  logic [4:0] ser;
  logic [4:0] act;
  logic [4:0] don;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2:0] exp_q[$];
  logic [8:0] rx_got[$];

  always #5 clk = ~clk;

  uart_tx_if if0();
  uart_tx_if if1();
  uart_tx_if if2();
  uart_tx_if if3();
  uart_tx_if if4();

  assign if0.i_Tx_DV = dv[0];  assign if0.i_Tx_Byte = tx_byte;
  assign if1.i_Tx_DV = dv[1];  assign if1.i_Tx_Byte = tx_byte;
  assign if2.i_Tx_DV = dv[2];  assign if2.i_Tx_Byte = tx_byte;
  assign if3.i_Tx_DV = dv[3];  assign if3.i_Tx_Byte = tx_byte;
  assign if4.i_Tx_DV = dv[4];  assign if4.i_Tx_Byte = tx_byte;

  assign ser[0] = if0.o_Tx_Serial;  assign act[0] = if0.o_Tx_Active;  assign don[0] = if0.o_Tx_Done;
  assign ser[1] = if1.o_Tx_Serial;  assign act[1] = if1.o_Tx_Active;  assign don[1] = if1.o_Tx_Done;
  assign ser[2] = if2.o_Tx_Serial;  assign act[2] = if2.o_Tx_Active;  assign don[2] = if2.o_Tx_Done;
  assign ser[3] = if3.o_Tx_Serial;  assign act[3] = if3.o_Tx_Active;  assign don[3] = if3.o_Tx_Done;
  assign ser[4] = if4.o_Tx_Serial;  assign act[4] = if4.o_Tx_Active;  assign don[4] = if4.o_Tx_Done;

  uart_tx #(.CLKS_PER_BIT(4),  .PARITY(0), .STOP_BITS(1)) u_dut0 (.i_Clock(clk), .i_Reset(rst), .tx(if0));
  uart_tx #(.CLKS_PER_BIT(4),  .PARITY(2), .STOP_BITS(1)) u_dut1 (.i_Clock(clk), .i_Reset(rst), .tx(if1));
  uart_tx #(.CLKS_PER_BIT(4),  .PARITY(1), .STOP_BITS(1)) u_dut2 (.i_Clock(clk), .i_Reset(rst), .tx(if2));
  uart_tx #(.CLKS_PER_BIT(4),  .PARITY(0), .STOP_BITS(2)) u_dut3 (.i_Clock(clk), .i_Reset(rst), .tx(if3));
  uart_tx #(.CLKS_PER_BIT(87), .PARITY(0), .STOP_BITS(1)) u_dut4 (.i_Clock(clk), .i_Reset(rst), .tx(if4));

  function automatic int cpb_of(input int idx);
    return (idx == 4) ? 87 : 4;
  endfunction

  function automatic int par_of(input int idx);
    return (idx == 1) ? PARITY_EVEN : (idx == 2) ? PARITY_ODD : PARITY_NONE;
  endfunction

  function automatic int sb_of(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  // Pushes the expected {line, active, done} for every cycle after acceptance, then strobes the byte.
  task automatic push_frame(input int idx, input logic [7:0] b);
    logic bq[$];
    int   ones;
    logic pbit;
    ones = 0;
    bq.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bq.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (par_of(idx) == PARITY_EVEN) begin
      pbit = (ones % 2 == 1);
      bq.push_back(pbit);
    end else if (par_of(idx) == PARITY_ODD) begin
      pbit = (ones % 2 == 0);
      bq.push_back(pbit);
    end
    for (int i = 0; i < sb_of(idx); i++) bq.push_back(1'b1);
    foreach (bq[i]) begin
      for (int c = 0; c < cpb_of(idx); c++) exp_q.push_back({bq[i], 1'b1, 1'b0});
    end
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b100);
    dv[idx] = 1'b1;
    tx_byte = b;
    @(posedge clk);
    #1 dv[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if ({ser[i], act[i], don[i]} !== 3'b100) begin
          tests_failed++;
          $display("FAIL idle[%0d]: line/active/done=%b%b%b required 100", i, ser[i], act[i], don[i]);
        end
      end
    end
  endtask

  task automatic test_frame_formats();
    int         idx_t[5];
    logic [7:0] byte_t[5];
    logic [2:0] e;
    int         cyc;
    idx_t  = '{0, 1, 2, 3, 0};
    byte_t = '{8'h3F, 8'hA5, 8'hA5, 8'h00, 8'hC3};
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      push_frame(idx_t[t], byte_t[t]);
      cyc = 0;
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        tests_run++;
        if ({ser[idx_t[t]], act[idx_t[t]], don[idx_t[t]]} !== e) begin
          tests_failed++;
          $display("FAIL frame dut%0d byte %h cyc %0d: line/active/done=%b%b%b required %b",
                   idx_t[t], byte_t[t], cyc, ser[idx_t[t]], act[idx_t[t]], don[idx_t[t]], e);
        end
        cyc++;
      end
    end
  endtask

  task automatic test_ignore_dv();
    logic [2:0] e;
    int         n;
    @(negedge clk);
    push_frame(0, 8'h81);
    n = exp_q.size();
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge clk);
      dv[0] = 1'b0;
      e = exp_q.pop_front();
      tests_run++;
      if ({ser[0], act[0], don[0]} !== e) begin
        tests_failed++;
        $display("FAIL ignore_dv cyc %0d: line/active/done=%b%b%b required %b", cyc, ser[0], act[0], don[0], e);
      end
      // One strobe mid-DATA and one while CLEANUP is showing done.
      if (cyc == 16 || cyc == n - 2) begin
        dv[0]   = 1'b1;
        tx_byte = 8'h55;
      end
    end
    dv[0] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      tests_run++;
      if ({ser[0], act[0], don[0]} !== 3'b100) begin
        tests_failed++;
        $display("FAIL ignore_dv tail: line/active/done=%b%b%b required 100", ser[0], act[0], don[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] e;
    int         cyc;
    @(negedge clk);
    push_frame(0, 8'h00);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if ({ser[0], act[0], don[0]} !== e) begin
        tests_failed++;
        $display("FAIL pre_reset cyc %0d: line/active/done=%b%b%b required %b", c, ser[0], act[0], don[0], e);
      end
    end
    exp_q.delete();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({ser[0], act[0], don[0]} !== 3'b100) begin
      tests_failed++;
      $display("FAIL async_reset: line/active/done=%b%b%b required 100", ser[0], act[0], don[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      tests_run++;
      if ({ser[0], act[0], don[0]} !== 3'b100) begin
        tests_failed++;
        $display("FAIL post_reset: line/active/done=%b%b%b required 100", ser[0], act[0], don[0]);
      end
    end
    push_frame(0, 8'h3C);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if ({ser[0], act[0], don[0]} !== e) begin
        tests_failed++;
        $display("FAIL after_reset cyc %0d: line/active/done=%b%b%b required %b", cyc, ser[0], act[0], don[0], e);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes_t[4];
    logic [7:0] sent_q[$];
    logic [8:0] got;
    int         n;
    bytes_t = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
    rx_got.delete();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dv[4]   = 1'b1;
      tx_byte = bytes_t[i];
      n = 0;
      while (act[4] !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      dv[4] = 1'b0;
      sent_q.push_back(bytes_t[i]);
      tests_run++;
      if (n != ((i == 0) ? 1 : 2)) begin
        tests_failed++;
        $display("FAIL accept_delay byte %0d: cycles=%0d required %0d", i, n, (i == 0) ? 1 : 2);
      end
      n = 0;
      while (don[4] !== 1'b1 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      tests_run++;
      if (don[4] !== 1'b1) begin
        tests_failed++;
        $display("FAIL done_timeout byte %0d: done=%b required 1", i, don[4]);
      end
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (rx_got.size() != 4) begin
      tests_failed++;
      $display("FAIL rx_count: got %0d bytes required 4", rx_got.size());
    end
    while (sent_q.size() > 0 && rx_got.size() > 0) begin
      got = rx_got.pop_front();
      tests_run++;
      if (got !== {1'b1, sent_q[0]}) begin
        tests_failed++;
        $display("FAIL loopback: stop_ok/byte=%b/%h required 1/%h", got[8], got[7:0], sent_q[0]);
      end
      void'(sent_q.pop_front());
    end
  endtask

  // Receiver model for the 87-clock instance: mid-bit sampling after a start edge.
  initial begin : rx_model
    logic [7:0] r;
    logic       ok;
    forever begin
      @(negedge clk);
      if (ser[4] === 1'b0) begin
        repeat (43) @(negedge clk);
        ok = (ser[4] === 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (87) @(negedge clk);
          r[k] = ser[4];
        end
        repeat (87) @(negedge clk);
        ok = ok & (ser[4] === 1'b1);
        rx_got.push_back({ok, r});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_frame_formats();
    test_ignore_dv();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
